// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative AES-128 key schedule, one round key per cycle, indexed read port.
// Optional macro KEYSCHED_INV_EN: rk_inv=1 maps the read index to 10 - rk_idx.

module sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] b;
      p = 8'h00;
      b = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ b;
         b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] inv;

   // Multiplicative inverse as a^254 = product of a^(2^k), k=1..7; zero maps to zero.
   always_comb begin
      logic [7:0] sq;
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module aes_key_sched_ctrl #(
   parameter int ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   output logic         keys_ready,
   output logic         exp_done,
   input  logic         rk_rd_en,
   input  logic [3:0]   rk_idx,
   input  logic         rk_inv,
   output logic [127:0] rk_data,
   output logic         rk_rd_valid,
   output logic         rk_err
);
   localparam logic [3:0] LAST = 4'(ROUNDS);

   generate
      if (ROUNDS != 10) begin : g_bad_rounds
         $error("aes_key_sched_ctrl supports only ROUNDS = 10");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   state_t       state;
   state_t       state_nx;
   logic [3:0]   rc;
   logic [127:0] store [0:10];
   logic         accept;
   logic [127:0] prev_key;
   logic [31:0]  rot;
   logic [31:0]  sub;
   logic [31:0]  t;
   logic [31:0]  n0, n1, n2, n3;
   logic [7:0]   rcon;
   logic [3:0]   eff_idx;

   assign accept = key_valid && key_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = EXPAND;
         EXPAND:  if (rc == LAST) state_nx = READY;
         READY:   if (accept) state_nx = EXPAND;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      key_ready  = 1'b1;
      keys_ready = 1'b0;
      case (state)
         IDLE:    begin key_ready = 1'b1; keys_ready = 1'b0; end
         EXPAND:  begin key_ready = 1'b0; keys_ready = 1'b0; end
         READY:   begin key_ready = 1'b1; keys_ready = 1'b1; end
         default: begin key_ready = 1'b1; keys_ready = 1'b0; end
      endcase
   end

   always_comb begin
      case (rc)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // Single shared 4-byte S-box path applied to RotWord(w3) of the previous slot.
   assign prev_key = store[rc - 4'd1];
   assign rot      = {prev_key[23:0], prev_key[31:24]};

   sbox u_sbox0 (.a(rot[31:24]), .s(sub[31:24]));
   sbox u_sbox1 (.a(rot[23:16]), .s(sub[23:16]));
   sbox u_sbox2 (.a(rot[15:8]),  .s(sub[15:8]));
   sbox u_sbox3 (.a(rot[7:0]),   .s(sub[7:0]));

   assign t  = sub ^ {rcon, 24'h0};
   assign n0 = prev_key[127:96] ^ t;
   assign n1 = prev_key[95:64]  ^ n0;
   assign n2 = prev_key[63:32]  ^ n1;
   assign n3 = prev_key[31:0]   ^ n2;

   always_ff @(posedge clk) begin
      if (rst) begin
         rc       <= 4'd0;
         exp_done <= 1'b0;
      end else begin
         exp_done <= (state == EXPAND) && (rc == LAST);
         if (accept)
            rc <= 4'd1;
         else if (state == EXPAND)
            rc <= rc + 4'd1;
      end
   end

   // The store is deliberately not cleared by reset; the FSM alone gates readability.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept)
            store[0] <= key_in;
         else if (state == EXPAND)
            store[rc] <= {n0, n1, n2, n3};
      end
   end

`ifdef KEYSCHED_INV_EN
   assign eff_idx = rk_inv ? (4'd10 - rk_idx) : rk_idx;
`else
   logic unused_inv;
   assign unused_inv = rk_inv;
   assign eff_idx    = rk_idx;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rk_data     <= 128'h0;
         rk_rd_valid <= 1'b0;
         rk_err      <= 1'b0;
      end else if (rk_rd_en) begin
         if (state == READY && rk_idx <= 4'd10) begin
            rk_data     <= store[eff_idx];
            rk_rd_valid <= 1'b1;
            rk_err      <= 1'b0;
         end else begin
            rk_data     <= 128'h0;
            rk_rd_valid <= 1'b0;
            rk_err      <= 1'b1;
         end
      end else begin
         rk_rd_valid <= 1'b0;
         rk_err      <= 1'b0;
      end
   end
endmodule
